// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------------------------
// shift_seq_ctrl
//
// Multi-cycle sequencer for the register-specified barrel-shift operand. The shifter does not
// compute the result in a single cycle. It loads the operand and then walks it one bit per
// cycle; the optional fast mode walks four bits per cycle. The pipeline is stalled while the
// walk runs. The result and the shifter carry are published on a one-cycle done pulse. They
// then hold their values until the next request is accepted.
//
// Configuration:
//   SHIFT_SEQ_FAST_EN  when defined, a SHIFT cycle advances 4 bits while at least 4 steps remain
//                      and 1 bit otherwise. Results are identical; only latency changes.
//
// Parameters:
//   CNT_W       width of the remaining-step counter (must hold 0..33)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request a shift (accepted only in IDLE without flush)
//   flush       abort the current operation, return to IDLE
//   shift_type  00 LSL, 01 LSR, 10 ASR, 11 ROR
//   val_rm      operand to shift
//   shift_amt   shift amount (Rs[7:0])
//   carry_in    current C flag
//   busy        state is not IDLE
//   stall       hold upstream stages
//   done        one-cycle result-valid pulse
//   val2        shifted result (held until next accept)
//   carry_out   shifter carry (held until next accept)
// ---------------------------------------------------------------------------------------------

module shift_seq_ctrl #(
   parameter int unsigned CNT_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [1:0]  shift_type,
   input  logic [31:0] val_rm,
   input  logic [7:0]  shift_amt,
   input  logic        carry_in,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] val2,
   output logic        carry_out
);

   localparam logic [1:0] ShLsl = 2'b00;
   localparam logic [1:0] ShLsr = 2'b01;
   localparam logic [1:0] ShAsr = 2'b10;
   localparam logic [1:0] ShRor = 2'b11;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StShift = 2'b01,
      StDone  = 2'b10
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       work_q, work_d;
   logic              wcarry_q, wcarry_d;
   logic [1:0]        type_q, type_d;
   logic [31:0]       val2_q, val2_d;
   logic              cout_q, cout_d;

   // Load-time values derived from the request
   logic [CNT_W-1:0]  n_load;
   logic              c_init;

   // One-bit step and the chosen step of the working operand
   logic [31:0]       one_val;
   logic              one_c;
   logic [31:0]       step_val;
   logic              step_c;
   logic [CNT_W-1:0]  step_cnt;

   // ------------------------------------------------------------------------------------------
   // Step count and initial carry for a new request
   // ------------------------------------------------------------------------------------------
   always_comb begin
      n_load = '0;
      unique case (shift_type)
         ShLsl, ShLsr: begin
            // 33 steps clear the operand and also shift the last carry out as 0
            n_load = (shift_amt > 8'd33) ? CNT_W'(33) : CNT_W'(shift_amt);
         end
         ShAsr: begin
            // Beyond 32 the result is all sign bits; more steps change nothing
            n_load = (shift_amt > 8'd32) ? CNT_W'(32) : CNT_W'(shift_amt);
         end
         ShRor: begin
            n_load = CNT_W'(shift_amt[4:0]);
         end
         default: n_load = '0;
      endcase
   end

   // A rotate by a non-zero multiple of 32 leaves the operand but reports bit31 as the carry;
   // an amount of exactly zero passes the incoming C flag through.
   always_comb begin
      c_init = carry_in;
      if ((shift_type == ShRor) && (shift_amt != 8'd0) && (shift_amt[4:0] == 5'd0)) begin
         c_init = val_rm[31];
      end
   end

   // ------------------------------------------------------------------------------------------
   // Datapath step
   // ------------------------------------------------------------------------------------------
   always_comb begin
      one_val = work_q;
      one_c   = wcarry_q;
      unique case (type_q)
         ShLsl: begin
            one_val = {work_q[30:0], 1'b0};
            one_c   = work_q[31];
         end
         ShLsr: begin
            one_val = {1'b0, work_q[31:1]};
            one_c   = work_q[0];
         end
         ShAsr: begin
            one_val = {work_q[31], work_q[31:1]};
            one_c   = work_q[0];
         end
         ShRor: begin
            one_val = {work_q[0], work_q[31:1]};
            one_c   = work_q[0];
         end
         default: begin
            one_val = work_q;
            one_c   = wcarry_q;
         end
      endcase
   end

   always_comb begin
      step_val = one_val;
      step_c   = one_c;
      step_cnt = cnt_q - CNT_W'(1);
`ifdef SHIFT_SEQ_FAST_EN
      if (cnt_q >= CNT_W'(4)) begin
         step_cnt = cnt_q - CNT_W'(4);
         // The carry is the last of the four bits shifted out
         unique case (type_q)
            ShLsl: begin
               step_val = {work_q[27:0], 4'b0000};
               step_c   = work_q[28];
            end
            ShLsr: begin
               step_val = {4'b0000, work_q[31:4]};
               step_c   = work_q[3];
            end
            ShAsr: begin
               step_val = {{4{work_q[31]}}, work_q[31:4]};
               step_c   = work_q[3];
            end
            ShRor: begin
               step_val = {work_q[3:0], work_q[31:4]};
               step_c   = work_q[3];
            end
            default: begin
               step_val = one_val;
               step_c   = one_c;
            end
         endcase
      end
`endif
   end

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      wcarry_d = wcarry_q;
      type_d   = type_q;
      val2_d   = val2_q;
      cout_d   = cout_q;

      if (flush) begin
         // Abort from any state; the published result is left untouched
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  type_d   = shift_type;
                  work_d   = val_rm;
                  wcarry_d = c_init;
                  cnt_d    = n_load;
                  if (n_load == '0) begin
                     state_d = StDone;
                     val2_d  = val_rm;
                     cout_d  = c_init;
                  end else begin
                     state_d = StShift;
                  end
               end
            end
            StShift: begin
               work_d   = step_val;
               wcarry_d = step_c;
               cnt_d    = step_cnt;
               if (step_cnt == '0) begin
                  // Publish the result as DONE is entered, so done and val2 line up
                  state_d = StDone;
                  val2_d  = step_val;
                  cout_d  = step_c;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         work_q   <= '0;
         wcarry_q <= 1'b0;
         type_q   <= ShLsl;
         val2_q   <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         wcarry_q <= wcarry_d;
         type_q   <= type_d;
         val2_q   <= val2_d;
         cout_q   <= cout_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs; status is forced low while reset is asserted
   // ------------------------------------------------------------------------------------------
   always_comb begin
      busy      = ~rst & (state_q != StIdle);
      stall     = ~rst & (((state_q == StIdle) & start & ~flush) | (state_q == StShift));
      done      = ~rst & (state_q == StDone);
      val2      = val2_q;
      carry_out = cout_q;
   end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Scoreboard bench for shift_seq_ctrl. Each accepted request pushes its hand-computed result,
// carry and latency. A monitor on the falling edge pops the entry and compares it on every
// done pulse. The stimulus process checks status outputs, flush, reset and the held results.
// ---------------------------------------------------------------------------------------------

module tb_shift_seq_ctrl;

   localparam logic [1:0] LSL = 2'b00;
   localparam logic [1:0] LSR = 2'b01;
   localparam logic [1:0] ASR = 2'b10;
   localparam logic [1:0] ROR = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [1:0]  shift_type;
   logic [31:0] val_rm;
   logic [7:0]  shift_amt;
   logic        carry_in;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] val2;
   logic        carry_out;

   typedef struct {
      logic [31:0] v;
      logic        c;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   shift_seq_ctrl #(.CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .flush      (flush),
      .shift_type (shift_type),
      .val_rm     (val_rm),
      .shift_amt  (shift_amt),
      .carry_in   (carry_in),
      .busy       (busy),
      .stall      (stall),
      .done       (done),
      .val2       (val2),
      .carry_out  (carry_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_lat(input int n);
`ifdef SHIFT_SEQ_FAST_EN
      return n / 4 + n % 4 + 1;
`else
      return n + 1;
`endif
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got val2=%h carry=%b expected no pulse", val2,
                     carry_out);
         end else begin
            e = sb.pop_front();
            check("val2", val2, e.v);
            check("carry_out", {31'd0, carry_out}, {31'd0, e.c});
            check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
         end
      end
   end

   // Present a request for one cycle; optionally push the expected response
   task automatic issue(input logic [1:0] t, input logic [31:0] v, input logic [7:0] a,
                        input logic ci, input logic [31:0] ev, input logic ec, input int n,
                        input bit push);
      exp_t x;
      @(negedge clk);
      start      = 1'b1;
      shift_type = t;
      val_rm     = v;
      shift_amt  = a;
      carry_in   = ci;
      #1;
      check("stall_on_accept", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         x.v   = ev;
         x.c   = ec;
         x.lat = exp_lat(n);
         x.acc = cyc;
         sb.push_back(x);
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL timeout: busy still 1 expected 0 within 200 cycles");
      end
   endtask

   task automatic run(input logic [1:0] t, input logic [31:0] v, input logic [7:0] a,
                      input logic ci, input logic [31:0] ev, input logic ec, input int n);
      issue(t, v, a, ci, ev, ec, n, 1'b1);
      wait_idle();
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      flush      = 1'b0;
      shift_type = LSL;
      val_rm     = '0;
      shift_amt  = '0;
      carry_in   = 1'b0;

      // Reset state, with start held to show stall stays low in reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_val2", val2, 32'd0);
      check("rst_carry", {31'd0, carry_out}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors: type, operand, amount, C, result, carry, N
      run(LSL, 32'h0000_0001, 8'd4,   1'b0, 32'h0000_0010, 1'b0, 4);
      run(LSR, 32'h8000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 32);
      run(LSR, 32'h8000_0001, 8'd40,  1'b0, 32'h0000_0000, 1'b0, 33);
      run(ASR, 32'h8000_0000, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 32);
      run(ROR, 32'h0000_000F, 8'd36,  1'b0, 32'hF000_0000, 1'b1, 4);
      run(ROR, 32'h8000_0000, 8'd32,  1'b0, 32'h8000_0000, 1'b1, 0);
      run(LSL, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 0);
      // Stall must drop once the zero-length op is in DONE
      check("stall_after_zero", {31'd0, stall}, 32'd0);
      run(LSL, 32'h8000_0001, 8'd1,   1'b0, 32'h0000_0002, 1'b1, 1);
      run(ASR, 32'h7FFF_FFF0, 8'd3,   1'b1, 32'h0FFF_FFFE, 1'b0, 3);
      run(LSL, 32'hFFFF_FFFF, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 32);
      run(LSL, 32'hFFFF_FFFF, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 33);
      run(ROR, 32'h0000_0001, 8'd1,   1'b0, 32'h8000_0000, 1'b1, 1);
      run(LSR, 32'h0000_00F0, 8'd5,   1'b0, 32'h0000_0007, 1'b1, 5);

      // Result holds while idle
      repeat (3) @(negedge clk);
      check("hold_val2", val2, 32'h0000_0007);
      check("hold_carry", {31'd0, carry_out}, 32'd1);

      // Start while busy must not relatch anything
      issue(LSR, 32'h8000_0001, 8'd32, 1'b0, 32'h0000_0000, 1'b1, 32, 1'b1);
      @(negedge clk);
      start      = 1'b1;
      shift_type = LSL;
      val_rm     = 32'hDEAD_BEEF;
      shift_amt  = 8'd1;
      carry_in   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();

      // Flush on the second SHIFT cycle of a 10-step op; previous result stays
      run(LSR, 32'h0000_00F0, 8'd5, 1'b0, 32'h0000_0007, 1'b1, 5);
      issue(LSL, 32'h0000_0001, 8'd10, 1'b0, 32'h0, 1'b0, 10, 1'b0);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("stall_shift_flush", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_stall", {31'd0, stall}, 32'd0);
      check("flush_done", {31'd0, done}, 32'd0);
      check("flush_val2", val2, 32'h0000_0007);
      check("flush_carry", {31'd0, carry_out}, 32'd1);
      // Accepted again in the following cycle
      run(LSL, 32'h0000_0001, 8'd4, 1'b0, 32'h0000_0010, 1'b0, 4);

      // Flush and start together in IDLE: request dropped
      @(negedge clk);
      start     = 1'b1;
      flush     = 1'b1;
      val_rm    = 32'h0000_0003;
      shift_amt = 8'd0;
      #1;
      check("flush_start_stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      check("flush_start_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("flush_start_val2", val2, 32'h0000_0010);

      // Reset mid-SHIFT abandons the op and clears the outputs
      issue(LSL, 32'h0000_FFFF, 8'd20, 1'b0, 32'h0, 1'b0, 20, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      flush = 1'b1;
      #1;
      check("rst_mid_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      check("rst_mid_val2", val2, 32'd0);
      check("rst_mid_carry", {31'd0, carry_out}, 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      repeat (30) @(negedge clk);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
